// File: rtl/boot_loader_ctrl_if.sv
// boot_loader_ctrl_if: UART byte input, fetch address and program-memory port of the boot loader.
interface boot_loader_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [31:0] fetch_addr;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;
  modport master (
    output rx_valid, rx_data, fetch_addr,
    input  mem_addr, mem_we, mem_wdata, cpu_run, load_done, load_error, words_loaded
  );
  modport slave (
    input  rx_valid, rx_data, fetch_addr,
    output mem_addr, mem_we, mem_wdata, cpu_run, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: loads a UART frame (sync, 16-bit LE length, LE words) into program memory, then
// gives the memory port to fetch and releases the core. Define CHECKSUM_EN for a trailing XOR byte.
module boot_loader_ctrl #(
  parameter int         MEM_WORDS      = 1024,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input logic               clk,
  input logic               reset_n,
  boot_loader_ctrl_if.slave bl
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_LEN = 17'(MEM_WORDS);
`ifdef CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHK, RUN, ERROR} state_e;
`else
  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, RUN, ERROR} state_e;
`endif
  state_e state_q;
  logic [15:0] len_q, words_q, len_w;
  logic [23:0] wbuf_q;
  logic [1:0] idx_q;
  logic [31:0] addr_q, wdata_q;
  logic we_q, run_q, done_q, err_q, in_frame, sync, timeout;
  logic [TW-1:0] tmo_q;
  assign len_w = {bl.rx_data, len_q[7:0]};
  assign sync = bl.rx_valid && bl.rx_data == SYNC_BYTE;
  assign in_frame = !(state_q inside {IDLE, RUN, ERROR});
  assign timeout = in_frame && !bl.rx_valid && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign bl.mem_addr = state_q == RUN ? bl.fetch_addr : addr_q;
  assign bl.mem_we = we_q;
  assign bl.mem_wdata = wdata_q;
  assign bl.cpu_run = run_q;
  assign bl.load_done = done_q;
  assign bl.load_error = err_q;
  assign bl.words_loaded = words_q;
`ifdef CHECKSUM_EN
  logic [7:0] chk_q;
  always_ff @(posedge clk) begin
    if (!reset_n || (sync && state_q inside {IDLE, ERROR})) chk_q <= '0;
    else if (bl.rx_valid && state_q inside {LEN_LO, LEN_HI, DATA}) chk_q <= chk_q ^ bl.rx_data;
  end
`endif
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      len_q <= '0;
      words_q <= '0;
      wbuf_q <= '0;
      idx_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      run_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      we_q <= 1'b0;
      tmo_q <= in_frame && !bl.rx_valid && !timeout ? tmo_q + TW'(1) : '0;
      if (timeout) begin
        state_q <= ERROR;
        err_q <= 1'b1;
      end else begin
        case (state_q)
          IDLE, ERROR: if (sync) begin
            state_q <= LEN_LO;
            err_q <= 1'b0;
            words_q <= '0;
            idx_q <= '0;
          end
          LEN_LO: if (bl.rx_valid) begin
            len_q[7:0] <= bl.rx_data;
            state_q <= LEN_HI;
          end
          LEN_HI: if (bl.rx_valid) begin
            len_q <= len_w;
            if (len_w == 16'd0) begin
`ifdef CHECKSUM_EN
              state_q <= CHK;
`else
              state_q <= RUN;
              run_q <= 1'b1;
              done_q <= 1'b1;
`endif
            end else if ({1'b0, len_w} > MAX_LEN) begin
              state_q <= ERROR;
              err_q <= 1'b1;
            end else state_q <= DATA;
          end
          // words_q == len_q only while the final write pulse is on the port
          DATA: if (words_q == len_q) begin
            state_q <= RUN;
            run_q <= 1'b1;
            done_q <= 1'b1;
          end else if (bl.rx_valid) begin
            idx_q <= idx_q + 2'd1;
            wbuf_q <= {bl.rx_data, wbuf_q[23:8]};
            if (idx_q == 2'd3) begin
              we_q <= 1'b1;
              wdata_q <= {bl.rx_data, wbuf_q};
              addr_q <= {14'd0, words_q, 2'b00};
              words_q <= words_q + 16'd1;
`ifdef CHECKSUM_EN
              if (words_q + 16'd1 == len_q) state_q <= CHK;
`endif
            end
          end
`ifdef CHECKSUM_EN
          CHK: if (bl.rx_valid) begin
            state_q <= bl.rx_data == chk_q ? RUN : ERROR;
            run_q <= bl.rx_data == chk_q;
            done_q <= bl.rx_data == chk_q;
            err_q <= bl.rx_data != chk_q;
          end
`endif
          default: ;
        endcase
      end
    end
  end
endmodule
